// File: rtl/mem_arb_if.sv
// Bundle of every handshake and bus signal around the memory arbiter.
// The "master" modport is the arbiter's view: it drives grants, responses
// and the shared memory bus. The "slave" modport is the view of the fetch
// unit, the IEU load/store path and the memory subsystem.
interface mem_arb_if #(
  parameter int XLEN = 32
);
  // fetch port
  logic              if_req;
  logic [XLEN-1:0]   if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [XLEN-1:0]   if_rdata;
  logic              if_err;
  // data port
  logic              d_req;
  logic              d_we;
  logic [XLEN-1:0]   d_addr;
  logic [XLEN-1:0]   d_wdata;
  logic [XLEN/8-1:0] d_be;
  logic              d_gnt;
  logic              d_rvalid;
  logic [XLEN-1:0]   d_rdata;
  logic              d_err;
  // shared memory bus
  logic              mem_req;
  logic              mem_we;
  logic [XLEN-1:0]   mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [XLEN/8-1:0] mem_be;
  logic              mem_ack;
  logic [XLEN-1:0]   mem_rdata;

  modport master (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata, if_err,
    input  d_req, d_we, d_addr, d_wdata, d_be,
    output d_gnt, d_rvalid, d_rdata, d_err,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ack, mem_rdata
  );

  modport slave (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata, if_err,
    output d_req, d_we, d_addr, d_wdata, d_be,
    input  d_gnt, d_rvalid, d_rdata, d_err,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_arb.sv
// Two-port memory arbiter: fetch and load/store share one memory bus.
// One transaction outstanding at a time; ties round-robin against the
// previous owner; a bounded wait turns a missing ack into an error response.
module mem_arb #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic      clk,
  input  logic      rst_n,
  mem_arb_if.master bus
);
  localparam int BW = XLEN / 8;
  // Counter only ever needs to reach TIMEOUT-1; keep at least one bit so
  // TIMEOUT=0 (never time out) still elaborates.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state_reg;
  logic            owner_reg;
  logic            last_reg;
  logic [CW-1:0]   cnt_reg;
  logic            mem_req_reg;
  logic            mem_we_reg;
  logic [XLEN-1:0] mem_addr_reg;
  logic [XLEN-1:0] mem_wdata_reg;
  logic [BW-1:0]   mem_be_reg;
  // Response registers indexed by owner (0 = fetch, 1 = data).
  logic [1:0]      rvalid_reg;
  logic [1:0]      err_reg;
  logic [XLEN-1:0] rdata_reg [2];

  logic            grant_if;
  logic            grant_d;
  logic            timeout_hit;

  // Grant decision: only in IDLE, ties go to the port not served last.
  always_comb begin
    grant_if = 1'b0;
    grant_d  = 1'b0;
    if (rst_n && state_reg == IDLE) begin
      grant_d  = bus.d_req  && (!bus.if_req || last_reg == OWN_IF);
      grant_if = bus.if_req && (!bus.d_req  || last_reg == OWN_D);
    end
  end

  // Last permitted BUSY cycle reached without an ack.
  always_comb begin
    timeout_hit = 1'b0;
    if (TIMEOUT > 0)
      timeout_hit = (cnt_reg == CNT_LAST);
  end

  // Transaction FSM with registered bus and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      owner_reg     <= OWN_IF;
      last_reg      <= OWN_IF;
      cnt_reg       <= '0;
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      mem_be_reg    <= '0;
      rvalid_reg    <= '0;
      err_reg       <= '0;
      rdata_reg[0]  <= '0;
      rdata_reg[1]  <= '0;
    end else begin
      rvalid_reg <= '0;
      case (state_reg)
        IDLE: begin
          if (grant_if || grant_d) begin
            state_reg   <= BUSY;
            mem_req_reg <= 1'b1;
            owner_reg   <= grant_d;
            last_reg    <= grant_d;
            cnt_reg     <= '0;
            if (grant_d) begin
              mem_we_reg    <= bus.d_we;
              mem_addr_reg  <= bus.d_addr;
              mem_wdata_reg <= bus.d_wdata;
              mem_be_reg    <= bus.d_be;
            end else begin
              // fetch is always a full-width read
              mem_we_reg    <= 1'b0;
              mem_addr_reg  <= bus.if_addr;
              mem_wdata_reg <= '0;
              mem_be_reg    <= '1;
            end
          end
        end
        BUSY: begin
          if (bus.mem_ack) begin
            state_reg             <= IDLE;
            mem_req_reg           <= 1'b0;
            rvalid_reg[owner_reg] <= 1'b1;
            err_reg[owner_reg]    <= 1'b0;
            rdata_reg[owner_reg]  <= mem_we_reg ? '0 : bus.mem_rdata;
          end else if (timeout_hit) begin
            state_reg             <= IDLE;
            mem_req_reg           <= 1'b0;
            rvalid_reg[owner_reg] <= 1'b1;
            err_reg[owner_reg]    <= 1'b1;
            rdata_reg[owner_reg]  <= '0;
          end else if (cnt_reg != '1) begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.if_gnt    = grant_if;
  assign bus.d_gnt     = grant_d;
  assign bus.if_rvalid = rvalid_reg[0];
  assign bus.if_err    = err_reg[0];
  assign bus.if_rdata  = rdata_reg[0];
  assign bus.d_rvalid  = rvalid_reg[1];
  assign bus.d_err     = err_reg[1];
  assign bus.d_rdata   = rdata_reg[1];
  assign bus.mem_req   = mem_req_reg;
  assign bus.mem_we    = mem_we_reg;
  assign bus.mem_addr  = mem_addr_reg;
  assign bus.mem_wdata = mem_wdata_reg;
  assign bus.mem_be    = mem_be_reg;
endmodule
